// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared size encodings, data-port FSM states and lane helpers
package rv32i_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC1,
        ST_ACC2,
        ST_CAPT
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 8'b0000_0001;
            SIZE_HALF: return 8'b0000_0011;
            SIZE_WORD: return 8'b0000_1111;
            default:   return 8'b0000_0000;
        endcase
    endfunction

    // True when the access spills past the end of its word.
    function automatic logic is_split(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_HALF) && (offset == 2'b11)) ||
               ((size == SIZE_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/rv32i_dmem_align.sv
// rtl/rv32i_dmem_align.sv - store lane steering and load merge/extend logic
module rv32i_dmem_align
    import rv32i_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic        split,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [7:0]  st_be,
    output logic [63:0] st_data,
    output logic [31:0] ld_data
);

    logic [4:0]  shamt;
    logic [63:0] merged;
    logic [31:0] lo;
    logic        sext;

    assign shamt   = {offset, 3'b000};
    assign st_be   = size_mask(size) << offset;
    assign st_data = {32'b0, wdata} << shamt;

    // The second word only contributes when the access actually spans two words.
    assign merged  = {split ? word1 : 32'b0, word0};
    assign lo      = merged[shamt +: 32];
    assign sext    = ~is_unsigned;

    always_comb begin
        ld_data = 32'b0;
        case (size)
            SIZE_BYTE: ld_data = {{24{sext & lo[7]}}, lo[7:0]};
            SIZE_HALF: ld_data = {{16{sext & lo[15]}}, lo[15:0]};
            SIZE_WORD: ld_data = lo;
            default:   ld_data = 32'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_dmem_port.sv
// rtl/rv32i_dmem_port.sv - RV32I data-side access FSM driving a 1-cycle-latency RAM port
module rv32i_dmem_port
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] d_addr,
    output logic              d_we,
    output logic [3:0]        d_be,
    output logic [31:0]       d_wdata,
    input  logic [31:0]       d_rdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        offset_q, offset_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              split_q, split_d;
    logic              err_q, err_d;
    logic [31:0]       word0_q, word0_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic              d_we_q, d_we_d;
    logic [3:0]        d_be_q, d_be_d;
    logic [31:0]       d_wdata_q, d_wdata_d;

    logic              in_idle;
    logic [1:0]        al_size;
    logic [1:0]        al_offset;
    logic [31:0]       al_wdata;
    logic [31:0]       al_word0;
    logic [7:0]        st_be;
    logic [63:0]       st_data;
    logic [31:0]       ld_data;

    // In IDLE the lanes for the first access are built from the live request,
    // afterwards from the latched copy.
    assign in_idle   = (state_q == ST_IDLE);
    assign al_size   = in_idle ? req_size      : size_q;
    assign al_offset = in_idle ? req_addr[1:0] : offset_q;
    assign al_wdata  = in_idle ? req_wdata     : wdata_q;
    assign al_word0  = split_q ? word0_q       : d_rdata;

    rv32i_dmem_align u_align (
        .size        (al_size),
        .offset      (al_offset),
        .is_unsigned (uns_q),
        .split       (split_q),
        .wdata       (al_wdata),
        .word0       (al_word0),
        .word1       (d_rdata),
        .st_be       (st_be),
        .st_data     (st_data),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        offset_d    = offset_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        err_d       = err_q;
        word0_d     = word0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'b0;
        rsp_err_d   = 1'b0;
        d_addr_d    = d_addr_q;
        d_we_d      = 1'b0;
        d_be_d      = 4'b0;
        d_wdata_d   = d_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    offset_d = req_addr[1:0];
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    wdata_d  = req_wdata;
                    split_d  = is_split(req_size, req_addr[1:0]);
                    if (req_size == SIZE_ILL) begin
                        err_d   = 1'b1;
                        state_d = ST_CAPT;
                    end else begin
                        err_d     = 1'b0;
                        state_d   = ST_ACC1;
                        d_addr_d  = req_addr[ADDR_W+1:2];
                        d_we_d    = req_we;
                        d_be_d    = st_be[3:0];
                        d_wdata_d = st_data[31:0];
                    end
                end
            end
            ST_ACC1: begin
                if (split_q) begin
                    state_d   = ST_ACC2;
                    d_addr_d  = d_addr_q + ADDR_W'(1);
                    d_we_d    = we_q;
                    d_be_d    = st_be[7:4];
                    d_wdata_d = st_data[63:32];
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_ACC2: begin
                word0_d = d_rdata;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (err_q || we_q) ? 32'b0 : ld_data;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            offset_q    <= 2'b0;
            size_q      <= SIZE_BYTE;
            uns_q       <= 1'b0;
            wdata_q     <= 32'b0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            word0_q     <= 32'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            d_addr_q    <= '0;
            d_we_q      <= 1'b0;
            d_be_q      <= 4'b0;
            d_wdata_q   <= 32'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            err_q       <= err_d;
            word0_q     <= word0_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            d_addr_q    <= d_addr_d;
            d_we_q      <= d_we_d;
            d_be_q      <= d_be_d;
            d_wdata_q   <= d_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign d_addr    = d_addr_q;
    assign d_we      = d_we_q;
    assign d_be      = d_be_q;
    assign d_wdata   = d_wdata_q;

endmodule

// File: tb/tb_rv32i_dmem_port.sv
// tb/tb_rv32i_dmem_port.sv - scoreboard bench for rv32i_dmem_port with a byte-lane RAM model
module tb_rv32i_dmem_port;

    localparam int ADDR_W = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;

    rv32i_dmem_port #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .d_addr       (d_addr),
        .d_we         (d_we),
        .d_be         (d_be),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RAM: word index folded to 8 bits, read-first, one cycle latency.
    logic [31:0] mem [256];
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'b0;
        end else if (d_we) begin
            for (int i = 0; i < 4; i++)
                if (d_be[i]) mem[d_addr[7:0]][8*i +: 8] <= d_wdata[8*i +: 8];
        end
        d_rdata <= mem[d_addr[7:0]];
    end

    logic [31:0] ref_mem [256];

    function automatic logic [7:0] ref_rd(input logic [31:0] ba);
        int lane;
        lane = int'(ba[1:0]);
        return ref_mem[ba[9:2]][lane*8 +: 8];
    endfunction

    task automatic ref_wr(input logic [31:0] ba, input logic [7:0] b);
        int lane;
        lane = int'(ba[1:0]);
        ref_mem[ba[9:2]][lane*8 +: 8] = b;
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_latency", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge (cycle A+1).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input bit track);
        int   n;
        int   nbytes;
        bit   spans;
        exp_t e;
        logic [31:0] v;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        nbytes = 1 << size;
        spans  = (int'(addr[1:0]) + nbytes) > 4;
        v = 32'b0;
        if (size == 2'b11) begin
            e.err = 1'b1;
            e.cyc = cyc + 2;
        end else begin
            e.err = 1'b0;
            e.cyc = cyc + (spans ? 4 : 3);
            for (int i = 0; i < nbytes; i++) begin
                if (we) begin
                    if (track) ref_wr(addr + 32'(i), wdata[8*i +: 8]);
                end else begin
                    v[8*i +: 8] = ref_rd(addr + 32'(i));
                end
            end
            if (!we && !uns && size == 2'b00) v = {{24{v[7]}}, v[7:0]};
            if (!we && !uns && size == 2'b01) v = {{16{v[15]}}, v[15:0]};
        end
        e.rdata = v;
        if (track) sb.push_back(e);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        mem_clr      = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_d_addr", {2'b0, d_addr}, 32'd0);
        chk("rst_d_we", {31'b0, d_we}, 32'd0);
        chk("rst_d_be", {28'b0, d_be}, 32'd0);
        chk("rst_d_wdata", d_wdata, 32'd0);
        mem_clr = 1'b0;
        reset   = 1'b1;
        @(negedge clk);

        issue(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1);
        chk("sw_addr", {2'b0, d_addr}, 32'h40);
        chk("sw_be", {28'b0, d_be}, 32'hF);
        chk("sw_we", {31'b0, d_we}, 32'd1);
        chk("sw_wdata", d_wdata, 32'hDEADBEEF);

        issue(1'b1, 32'h103, 2'b10, 1'b0, 32'h11223344, 1'b1);
        chk("ssw_a1_addr", {2'b0, d_addr}, 32'h40);
        chk("ssw_a1_be", {28'b0, d_be}, 32'h8);
        chk("ssw_a1_byte", {24'b0, d_wdata[31:24]}, 32'h44);
        @(negedge clk);
        chk("ssw_a2_addr", {2'b0, d_addr}, 32'h41);
        chk("ssw_a2_be", {28'b0, d_be}, 32'h7);
        chk("ssw_a2_low", {8'b0, d_wdata[23:0]}, 32'h112233);
        chk("ssw_a2_we", {31'b0, d_we}, 32'd1);

        issue(1'b1, 32'h100, 2'b10, 1'b0, 32'h000080FF, 1'b1);
        issue(1'b0, 32'h101, 2'b00, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h101, 2'b00, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 32'h103, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 1'b1);

        issue(1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 1'b1);
        chk("ill_we", {31'b0, d_we}, 32'd0);
        chk("ill_be", {28'b0, d_be}, 32'd0);

        issue(1'b1, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'hA1B2C3D4, 1'b1);
        issue(1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h55667788, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0, 1'b1);
        chk("wrap_a1_addr", {2'b0, d_addr}, 32'h3FFF_FFFF);
        @(negedge clk);
        chk("wrap_a2_addr", {2'b0, d_addr}, 32'h0);
        issue(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 32'hFFFF_FFFD, 2'b10, 1'b0, 32'h0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = 32'h40 + 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b1);
        end

        issue(1'b1, 32'h204, 2'b10, 1'b0, 32'h12345678, 1'b1);
        issue(1'b1, 32'h200, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 32'h203, 2'b10, 1'b0, 32'hAABBCCDD, 1'b0);
        @(negedge clk);
        chk("rstm_acc2_we", {31'b0, d_we}, 32'd1);
        chk("rstm_acc2_addr", {2'b0, d_addr}, 32'h81);
        #1 reset = 1'b0;
        #1;
        chk("rstm_async_we", {31'b0, d_we}, 32'd0);
        chk("rstm_async_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("rstm_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstm_we", {31'b0, d_we}, 32'd0);
        reset = 1'b1;
        ref_wr(32'h203, 8'hDD);
        repeat (4) @(negedge clk);
        chk("rstm_no_rsp", {31'b0, rsp_valid}, 32'd0);

        issue(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h204, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h202, 2'b10, 1'b1, 32'h0, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
